// File: rtl/sc_updown_acc_bank_pkg.sv
// Shared types and arithmetic helpers for the stochastic up/down accumulator bank.
package sc_pkg;

   typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} sc_acc_state_t;

   // Bipolar coding: a '1' bit counts up, a '0' bit counts down.
   localparam logic BIPOLAR_UP = 1'b1;

   function automatic int sat_max(input int w);
      return (1 << (w - 1)) - 1;
   endfunction

   function automatic int sat_min(input int w);
      return -(1 << (w - 1));
   endfunction

endpackage

// File: rtl/sc_updown_acc_bank_cell.sv
// One channel: signed up/down counter with saturate/wrap selection and a sticky overflow flag.
module sc_updown_cell
   import sc_pkg::*;
#(
   parameter int ACC_W = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear,
   input  logic                    en,
   input  logic                    sn_bit,
   input  logic                    sat_en,
   output logic signed [ACC_W-1:0] acc_nxt,
   output logic                    ovf_nxt
);

   localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(sat_max(ACC_W));
   localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(sat_min(ACC_W));
   localparam logic signed [ACC_W-1:0] ONE   = ACC_W'(1);

   logic signed [ACC_W-1:0] acc_q;
   logic                    ovf_q;

   // acc_nxt/ovf_nxt are the values after this cycle's update, so the top can
   // latch the final result on the same edge that absorbs the last bit.
   always_comb begin
      acc_nxt = acc_q;
      ovf_nxt = ovf_q;
      if (en) begin
         if (sn_bit == BIPOLAR_UP) begin
            if (acc_q == MAX_V) begin
               acc_nxt = sat_en ? MAX_V : MIN_V;
               ovf_nxt = 1'b1;
            end else begin
               acc_nxt = acc_q + ONE;
            end
         end else begin
            if (acc_q == MIN_V) begin
               acc_nxt = sat_en ? MIN_V : MAX_V;
               ovf_nxt = 1'b1;
            end else begin
               acc_nxt = acc_q - ONE;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q <= '0;
         ovf_q <= 1'b0;
      end else if (clear) begin
         acc_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         acc_q <= acc_nxt;
         ovf_q <= ovf_nxt;
      end
   end

endmodule

// File: rtl/sc_updown_acc_bank.sv
// Bank of N_CH bipolar stochastic-bit accumulators framed by a start/done window.
module sc_updown_acc_bank
   import sc_pkg::*;
#(
   parameter int N_CH  = 4,
   parameter int ACC_W = 8,
   parameter int LEN_W = 8
) (
   input  logic                  i_clk_udc,
   input  logic                  i_rst_udc,
   input  logic                  i_start,
   input  logic [LEN_W-1:0]      i_len,
   input  logic                  i_sat_en,
   input  logic                  i_bit_valid,
   input  logic [N_CH-1:0]       i_sn_bits,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [N_CH*ACC_W-1:0] o_result,
   output logic [N_CH-1:0]       o_ovf
);

   sc_acc_state_t        state_q, state_d;
   logic [LEN_W-1:0]     remaining;
   logic                 sat_q;
   logic                 clear, step, last, load_zero;
   logic [N_CH*ACC_W-1:0] acc_nxt;
   logic [N_CH-1:0]      ovf_nxt;

   always_comb begin
      state_d   = state_q;
      clear     = 1'b0;
      step      = 1'b0;
      last      = 1'b0;
      load_zero = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               if (i_len != '0) begin
                  clear   = 1'b1;
                  state_d = S_ACC;
               end else begin
                  load_zero = 1'b1;
                  state_d   = S_DONE;
               end
            end
         end
         S_ACC: begin
            if (i_bit_valid) begin
               step = 1'b1;
               if (remaining == LEN_W'(1)) begin
                  last    = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk_udc or posedge i_rst_udc) begin
      if (i_rst_udc) begin
         state_q   <= S_IDLE;
         remaining <= '0;
         sat_q     <= 1'b0;
         o_busy    <= 1'b0;
         o_done    <= 1'b0;
         o_result  <= '0;
         o_ovf     <= '0;
      end else begin
         state_q <= state_d;
         // Busy and done are registered from the next state so both come straight off flops.
         o_busy  <= (state_d != S_IDLE);
         o_done  <= (state_d == S_DONE);
         if (clear) begin
            remaining <= i_len;
            sat_q     <= i_sat_en;
         end else if (step) begin
            remaining <= remaining - LEN_W'(1);
         end
         if (last) begin
            o_result <= acc_nxt;
            o_ovf    <= ovf_nxt;
         end else if (load_zero) begin
            o_result <= '0;
            o_ovf    <= '0;
         end
      end
   end

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      sc_updown_cell #(
         .ACC_W(ACC_W)
      ) u_cell (
         .clk    (i_clk_udc),
         .rst    (i_rst_udc),
         .clear  (clear),
         .en     (step),
         .sn_bit (i_sn_bits[c]),
         .sat_en (sat_q),
         .acc_nxt(acc_nxt[c*ACC_W +: ACC_W]),
         .ovf_nxt(ovf_nxt[c])
      );
   end

endmodule

// File: tb/tb_sc_updown_acc_bank.sv
// Randomised self-checking bench for sc_updown_acc_bank against an integer reference model.
module tb_sc_updown_acc_bank;

   localparam int N_CH  = 4;
   localparam int ACC_W = 4;
   localparam int LEN_W = 8;
   localparam int MAXV  = (1 << (ACC_W - 1)) - 1;
   localparam int MINV  = -(1 << (ACC_W - 1));

   logic                  i_clk_udc = 1'b0;
   logic                  i_rst_udc;
   logic                  i_start;
   logic [LEN_W-1:0]      i_len;
   logic                  i_sat_en;
   logic                  i_bit_valid;
   logic [N_CH-1:0]       i_sn_bits;
   logic                  o_busy;
   logic                  o_done;
   logic [N_CH*ACC_W-1:0] o_result;
   logic [N_CH-1:0]       o_ovf;

   int total = 0;
   int bad   = 0;
   logic [N_CH-1:0] bits_q[$];

   sc_updown_acc_bank #(
      .N_CH(N_CH), .ACC_W(ACC_W), .LEN_W(LEN_W)
   ) dut (
      .i_clk_udc  (i_clk_udc),
      .i_rst_udc  (i_rst_udc),
      .i_start    (i_start),
      .i_len      (i_len),
      .i_sat_en   (i_sat_en),
      .i_bit_valid(i_bit_valid),
      .i_sn_bits  (i_sn_bits),
      .o_busy     (o_busy),
      .o_done     (o_done),
      .o_result   (o_result),
      .o_ovf      (o_ovf)
   );

   always #5 i_clk_udc = ~i_clk_udc;

   function automatic int chan_val(input logic [N_CH*ACC_W-1:0] r, input int c);
      logic signed [ACC_W-1:0] s;
      s = r[c*ACC_W +: ACC_W];
      return int'(s);
   endfunction

   // vmode: 0 = valid every cycle, 1 = valid on odd cycles, 2 = random valid.
   task automatic run_window(input string name, input int len, input logic sat,
                             input int vmode, input bit inject_start);
      int exp_val[N_CH];
      logic [N_CH-1:0] exp_ovf;
      int exp_done, done_cyc, cyc, nvalid;
      bit busy_ok, v;
      logic [N_CH*ACC_W-1:0] exp_res;
      for (int c = 0; c < N_CH; c++) begin
         exp_val[c] = 0;
         exp_ovf[c] = 1'b0;
         for (int i = 0; i < len; i++) begin
            exp_val[c] += bits_q[i][c] ? 1 : -1;
            if (exp_val[c] > MAXV) begin
               exp_ovf[c] = 1'b1;
               exp_val[c] = sat ? MAXV : MINV;
            end else if (exp_val[c] < MINV) begin
               exp_ovf[c] = 1'b1;
               exp_val[c] = sat ? MINV : MAXV;
            end
         end
         exp_res[c*ACC_W +: ACC_W] = exp_val[c][ACC_W-1:0];
      end

      i_start = 1'b1; i_len = LEN_W'(len); i_sat_en = sat; i_bit_valid = 1'b0;
      @(posedge i_clk_udc); #1;
      i_start  = 1'b0;
      i_sat_en = ~sat;
      cyc = 1; nvalid = 0; done_cyc = -1; busy_ok = 1'b1;
      exp_done = (len == 0) ? 1 : -1;
      while (cyc <= 200) begin
         v = (vmode == 0) ? 1'b1 : (vmode == 1) ? bit'(cyc % 2) : bit'($urandom_range(0, 1));
         i_bit_valid = v;
         if (v && nvalid < len) begin
            i_sn_bits = bits_q[nvalid];
            nvalid++;
            if (nvalid == len) exp_done = cyc + 1;
         end else begin
            i_sn_bits = N_CH'($urandom);
         end
         i_start = inject_start && (cyc == 2);
         i_len   = inject_start ? LEN_W'($urandom_range(1, 30)) : LEN_W'(len);
         @(negedge i_clk_udc);
         if (!o_busy) busy_ok = 1'b0;
         if (o_done) begin
            done_cyc = cyc;
            break;
         end
         @(posedge i_clk_udc); #1;
         cyc++;
      end
      i_start = 1'b0; i_bit_valid = 1'b0;

      total++;
      if (done_cyc !== exp_done) begin
         bad++;
         $display("FAIL %s done_cycle: got %0d expected %0d", name, done_cyc, exp_done);
      end
      total++;
      if (busy_ok !== 1'b1) begin
         bad++;
         $display("FAIL %s busy_during_window: got 0 expected 1", name);
      end
      for (int c = 0; c < N_CH; c++) begin
         total++;
         if (chan_val(o_result, c) !== exp_val[c]) begin
            bad++;
            $display("FAIL %s result_ch%0d: got %0d expected %0d", name, c, chan_val(o_result, c), exp_val[c]);
         end
      end
      total++;
      if (o_ovf !== exp_ovf) begin
         bad++;
         $display("FAIL %s ovf: got %b expected %b", name, o_ovf, exp_ovf);
      end

      @(posedge i_clk_udc); #1;
      i_bit_valid = 1'b1;
      i_sn_bits   = N_CH'($urandom);
      @(negedge i_clk_udc);
      total++;
      if (o_done !== 1'b0 || o_busy !== 1'b0) begin
         bad++;
         $display("FAIL %s after_done: got done=%b busy=%b expected 0 0", name, o_done, o_busy);
      end
      total++;
      if (o_result !== exp_res) begin
         bad++;
         $display("FAIL %s result_hold: got %h expected %h", name, o_result, exp_res);
      end
      @(posedge i_clk_udc); #1;
      i_bit_valid = 1'b0;
   endtask

   task automatic build_pattern();
      logic [N_CH-1:0] b;
      bits_q.delete();
      for (int i = 0; i < 8; i++) begin
         b[0] = 1'b1;
         b[1] = 1'b0;
         b[2] = (i % 2 == 0);
         b[3] = (i % 4 != 3);
         bits_q.push_back(b);
      end
   endtask

   task automatic test_reset();
      i_rst_udc = 1'b1; i_start = 1'b0; i_len = '0; i_sat_en = 1'b0;
      i_bit_valid = 1'b0; i_sn_bits = '0;
      repeat (2) @(posedge i_clk_udc);
      @(negedge i_clk_udc);
      total++;
      if ({o_busy, o_done, o_result, o_ovf} !== '0) begin
         bad++;
         $display("FAIL reset_values: got busy=%b done=%b result=%h ovf=%b expected all 0",
                  o_busy, o_done, o_result, o_ovf);
      end
      i_rst_udc = 1'b0;
      @(posedge i_clk_udc); #1;
      @(negedge i_clk_udc);
      total++;
      if ({o_busy, o_done, o_result, o_ovf} !== '0) begin
         bad++;
         $display("FAIL after_reset_idle: got busy=%b done=%b result=%h ovf=%b expected all 0",
                  o_busy, o_done, o_result, o_ovf);
      end
      @(posedge i_clk_udc); #1;
   endtask

   task automatic test_pattern_sat();
      build_pattern();
      run_window("pattern_sat", 8, 1'b1, 0, 1'b0);
      total++;
      if (o_result !== 16'h4087 || o_ovf !== 4'b0001) begin
         bad++;
         $display("FAIL pattern_sat_literal: got %h/%b expected 4087/0001", o_result, o_ovf);
      end
   endtask

   task automatic test_pattern_wrap();
      build_pattern();
      run_window("pattern_wrap", 8, 1'b0, 0, 1'b0);
      total++;
      if (o_result !== 16'h4088 || o_ovf !== 4'b0001) begin
         bad++;
         $display("FAIL pattern_wrap_literal: got %h/%b expected 4088/0001", o_result, o_ovf);
      end
   endtask

   task automatic test_gapped_valid();
      bits_q.delete();
      for (int i = 0; i < 5; i++) bits_q.push_back(N_CH'($urandom) | N_CH'(1));
      run_window("gapped_len5", 5, 1'b1, 1, 1'b0);
      total++;
      if (chan_val(o_result, 0) !== 5) begin
         bad++;
         $display("FAIL gapped_ch0_literal: got %0d expected 5", chan_val(o_result, 0));
      end
   endtask

   task automatic test_len0_and_ignored_start();
      bits_q.delete();
      run_window("len0", 0, 1'b1, 0, 1'b0);
      build_pattern();
      run_window("start_during_acc", 8, 1'b1, 0, 1'b1);
   endtask

   task automatic test_reset_mid_window();
      bit done_seen;
      i_start = 1'b1; i_len = LEN_W'(8); i_sat_en = 1'b1;
      @(posedge i_clk_udc); #1;
      i_start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         i_bit_valid = 1'b1; i_sn_bits = '1;
         @(posedge i_clk_udc); #1;
      end
      #2;
      total++;
      if (o_busy !== 1'b1) begin
         bad++;
         $display("FAIL mid_window_busy: got %b expected 1", o_busy);
      end
      i_rst_udc = 1'b1;
      #1;
      total++;
      if ({o_busy, o_done, o_result, o_ovf} !== '0) begin
         bad++;
         $display("FAIL async_reset_outputs: got busy=%b done=%b result=%h ovf=%b expected all 0",
                  o_busy, o_done, o_result, o_ovf);
      end
      done_seen = 1'b0;
      repeat (3) begin
         @(negedge i_clk_udc);
         if (o_done) done_seen = 1'b1;
      end
      i_rst_udc = 1'b0;
      repeat (6) begin
         @(negedge i_clk_udc);
         if (o_done) done_seen = 1'b1;
      end
      total++;
      if (done_seen !== 1'b0) begin
         bad++;
         $display("FAIL no_done_after_reset: got 1 expected 0");
      end
      @(posedge i_clk_udc); #1;
      bits_q.delete();
      for (int i = 0; i < 2; i++) bits_q.push_back(N_CH'($urandom) | N_CH'(1));
      run_window("fresh_len2", 2, 1'b1, 0, 1'b0);
      total++;
      if (chan_val(o_result, 0) !== 2) begin
         bad++;
         $display("FAIL fresh_len2_ch0_literal: got %0d expected 2", chan_val(o_result, 0));
      end
   endtask

   task automatic test_random();
      int bias[N_CH];
      int len;
      logic [N_CH-1:0] b;
      for (int w = 0; w < 8; w++) begin
         for (int c = 0; c < N_CH; c++) bias[c] = (($urandom_range(0, 2)) * 40) + 10;
         len = $urandom_range(0, 24);
         bits_q.delete();
         for (int i = 0; i < len; i++) begin
            for (int c = 0; c < N_CH; c++) b[c] = ($urandom_range(0, 99) < bias[c]);
            bits_q.push_back(b);
         end
         run_window($sformatf("random_w%0d", w), len, 1'($urandom), 2, bit'($urandom_range(0, 1)));
      end
   endtask

   initial begin
      test_reset();
      test_pattern_sat();
      test_pattern_wrap();
      test_gapped_valid();
      test_len0_and_ignored_start();
      test_reset_mid_window();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sc_updown_acc_bank.md
# sc_updown_acc_bank

Parametrised multi-channel stochastic-number accumulator: a bank of N_CH signed up/down counters. Each counter integrates one bipolar bitstream over a programmable stream length: +1 per '1' bit, −1 per '0' bit. A start/done handshake frames each window. The block supports selectable saturating or wrapping arithmetic and sticky per-channel overflow flags. It sits behind the bitstream-generator FSM in the MVM datapath and replaces fixed 4-channel, 4-bit counters that are gated only by an enable.

## Interface
- N_CH, default 4: number of channels (≥1).
- ACC_W, default 8: accumulator width, signed two's complement (≥2).
- LEN_W, default 8: width of the stream-length field.
- i_clk_udc  in  1  clock, rising edge.
- i_rst_udc  in  1  reset, asynchronous, active-high; clock i_clk_udc.
- i_start  in  1  start pulse. Sampled only in IDLE.
- i_len  in  LEN_W  number of valid bits to accumulate. Sampled with i_start.
- i_sat_en  in  1  1 = saturate, 0 = wrap. Sampled with i_start and held internally for the window.
- i_bit_valid  in  1  i_sn_bits carries a valid bit this cycle.
- i_sn_bits  in  N_CH  one stochastic bit per channel.
- o_busy  out  1  high in ACC and DONE.
- o_done  out  1  one-cycle pulse: the window is complete and o_result is updated.
- o_result  out  N_CH×ACC_W  latched signed results, held until the next completion.
- o_ovf  out  N_CH  per-channel overflow flag, sticky within a window and latched with o_result.

## Operation
- Reset values: state IDLE; accumulators 0; remaining count 0; o_busy 0; o_done 0; o_result all 0; o_ovf all 0.
- IDLE
  - i_start with i_len ≠ 0: clear all accumulators and internal overflow flags, load remaining = i_len, latch the mode, go to ACC.
  - i_start with i_len = 0: go directly to DONE. o_result and o_ovf are loaded with zeros.
- ACC, on a cycle with i_bit_valid = 1:
  - For each channel c, acc[c] ← acc[c] + (i_sn_bits[c] ? +1 : −1); remaining ← remaining − 1.
  - If remaining = 1 before the decrement, this is the last bit: copy the post-update accumulators and flags into o_result/o_ovf and go to DONE.
- ACC, on a cycle with i_bit_valid = 0: hold all state.
- DONE: o_done = 1 for exactly one cycle, then unconditionally return to IDLE.
- Arithmetic limits: MAX = 2^(ACC_W−1)−1, MIN = −2^(ACC_W−1).
  - Saturating mode: +1 at MAX stays at MAX; −1 at MIN stays at MIN. Either case sets ovf[c].
  - Wrap mode: MAX+1 → MIN and MIN−1 → MAX. Either case sets ovf[c].
- Flag and output rules:
  - Reaching MIN or MAX exactly is not overflow.
  - ovf[c] clears only when a new window starts.
  - o_result/o_ovf change only on the edge that enters DONE (or on reset).
- i_start is ignored in ACC and DONE. No queuing.
- Reset mid-window: the window is abandoned and every output returns immediately to its reset value. No o_done is produced.

## Timing
- A start sampled at edge k puts the block in ACC from cycle k+1.
- With i_bit_valid held high, bits are sampled at edges k+1 … k+len.
  - o_done and the new o_result are visible in cycle k+len+1.
  - IDLE is reached at cycle k+len+2, so the earliest next start is sampled at edge k+len+2.
- len = 0 case: o_done in cycle k+1.
- Each invalid cycle in ACC adds one cycle of latency.
- Every output is driven directly from a register. There is no combinational path from inputs to outputs.
- o_busy rises in cycle k+1 and falls in the cycle after o_done.

## Structure
- Package sc_pkg holds:
  - typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} sc_acc_state_t;
  - the bipolar increment convention constant;
  - helper functions sat_max(w) and sat_min(w).
- Sub-module sc_updown_cell: one channel. Ports are clk, rst, clear, en, bit, sat_en; it outputs the ACC_W accumulator and the ovf flag. It is instantiated N_CH times by generate.
- The top level holds the FSM, the remaining-count register, the mode register, and the output latch registers.

## Test plan
- N_CH=4, ACC_W=4, len=8, sat_en=1, valid every cycle, bits ch0=1111…, ch1=0000…, ch2=1010…, ch3=1110 repeated:
  - o_result = {7, −8, 0, 4}, o_ovf = 4'b0001;
  - o_done exactly 9 cycles after the start edge.
- Same stimulus with sat_en=0: ch0 wraps to −8 and o_ovf[0] = 1; the other channels are unchanged.
- len=5, i_bit_valid toggled 1,0,1,0,… with ch0 all ones: o_result[0] = 5; o_done at cycle 10 after start; o_busy high throughout.
- i_start with i_len=0: o_done on the next cycle; o_result = 0; o_ovf = 0. A second i_start pulsed during ACC is ignored and the result is unaffected.
- Assert i_rst_udc asynchronously mid-window (after 3 of 8 bits): o_busy/o_done/o_result/o_ovf go to 0 immediately. A fresh start with len=2 and bits 11 then gives o_result[0] = 2.
